mem_access_unit: RTL and testbench

MEM-stage data-memory access unit of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the MEM/WB register. It issues loads and stores to a variable-latency data memory over a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and formats load data (byte/half/word, signed/unsigned). Its outputs are sampled by the MEM/WB register each cycle; during a stall they present a bubble.

---
 rtl/mem_access_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage data-memory access unit (5-stage MIPS).
//
// Sits between EX/MEM and MEM/WB. Non-memory instructions pass straight
// through combinationally. Aligned loads/stores are issued to a
// variable-latency data memory over a registered req / one-cycle ack
// handshake; the upstream pipeline is stalled (and a bubble presented to
// MEM/WB) until the access completes, times out, or reset intervenes.
// Misaligned accesses are dropped with a one-cycle misalign_err.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid              EX/MEM holds a live instruction
//   MemRead/MemWrite      load / store
//   RegWrite/MemtoReg     WB controls
//   ALUResult             effective address or ALU result
//   WriteData             store data
//   Rd                    destination register
//   mem_size/mem_unsigned access size (0 byte, 1 half, 2/3 word), zero-extend
//   stall                 freeze upstream pipeline this cycle
//   *_out                 values presented to MEM/WB
//   misalign_err/bus_err  one-cycle error pulses
//   dmem_*                data-memory request (registered) / response

// Per-byte-lane store formatting: byte enable and replicated write byte.
module mem_access_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mem_size,
    input  logic [31:0] store_data,
    output logic        be,
    output logic [7:0]  wdata
);
    localparam logic [1:0] IDX = 2'(LANE);

    always_comb begin
        be    = 1'b1;
        wdata = store_data[8*LANE +: 8];
        case (mem_size)
            2'd0: begin
                be    = (addr_lo == IDX);
                wdata = store_data[7:0];
            end
            2'd1: begin
                be    = (addr_lo[1] == IDX[1]);
                wdata = store_data[8*(LANE%2) +: 8];
            end
            default: begin
                be    = 1'b1;
                wdata = store_data[8*LANE +: 8];
            end
        endcase
    end
endmodule

module mem_access_unit #(
    parameter int TIMEOUT = 255   // BUSY cycles before abort, 0 = never
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [4:0]  Rd,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] ALUResult_out,
    output logic [31:0] ReadData_out,
    output logic [4:0]  Rd_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    state_t    state, state_next;
    dmem_req_t req_q, req_d;
    logic [31:0] load_q, load_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;

    logic        mem_op, misaligned, bubble;
    logic [NUM_LANES-1:0]        lane_be;
    logic [NUM_LANES-1:0][7:0]   lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic        timeout_hit;

    assign mem_op     = in_valid & (MemRead | MemWrite);
    assign misaligned = ((mem_size == 2'd1) & ALUResult[0])
                      | (mem_size[1] & (|ALUResult[1:0]));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mem_access_lane #(.LANE(i)) u_lane (
            .addr_lo    (ALUResult[1:0]),
            .mem_size   (mem_size),
            .store_data (WriteData),
            .be         (lane_be[i]),
            .wdata      (lane_wdata[i])
        );
    end

    // EX/MEM is frozen while BUSY, so address/size/sign are still valid at ack.
    always_comb begin
        ld_byte = dmem_rdata[{ALUResult[1:0], 3'b000} +: 8];
        ld_half = ALUResult[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (mem_size)
            2'd0:    ld_fmt = mem_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_fmt = mem_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // cnt_q counts completed BUSY cycles; the abort fires on the TIMEOUT-th.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= '0;
            load_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_next;
            req_q   <= req_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_next   = state;
        req_d        = req_q;
        load_d       = load_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        stall        = 1'b0;
        bubble       = 1'b0;
        misalign_err = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_err = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        bubble      = 1'b1;
                        req_d.req   = 1'b1;
                        req_d.we    = MemWrite;
                        req_d.addr  = {ALUResult[31:2], 2'b00};
                        req_d.wdata = lane_wdata;
                        req_d.be    = lane_be;
                        cnt_d       = '0;
                        abort_d     = 1'b0;
                        state_next  = BUSY;
                    end
                end
            end
            BUSY: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (dmem_ack) begin
                    req_d.req  = 1'b0;
                    load_d     = MemRead ? ld_fmt : 32'd0;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    req_d.req  = 1'b0;
                    load_d     = 32'd0;
                    abort_d    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MEM/WB-facing outputs: pass-through unless a bubble is being inserted.
    always_comb begin
        RegWrite_out  = RegWrite & in_valid & ~misalign_err
                      & ~((state == DONE) & abort_q);
        MemtoReg_out  = MemtoReg;
        ALUResult_out = ALUResult;
        Rd_out        = Rd;
        ReadData_out  = (state == DONE) ? load_q : 32'd0;
        if (bubble) begin
            RegWrite_out  = 1'b0;
            MemtoReg_out  = 1'b0;
            ALUResult_out = 32'd0;
            Rd_out        = 5'd0;
            ReadData_out  = 32'd0;
        end
    end

    assign bus_err    = (state == DONE) & abort_q;
    assign dmem_req   = req_q.req;
    assign dmem_we    = req_q.we;
    assign dmem_addr  = req_q.addr;
    assign dmem_wdata = req_q.wdata;
    assign dmem_be    = req_q.be;
endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of single-cycle pass-through and
// misalignment vectors, scoreboarded multi-cycle load/store sequences,
// a timeout abort, and reset during an outstanding access.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] ALUResult, WriteData;
    logic [4:0]  Rd;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        stall, RegWrite_out, MemtoReg_out;
    logic [31:0] ALUResult_out, ReadData_out;
    logic [4:0]  Rd_out;
    logic        misalign_err, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUResult(ALUResult), .WriteData(WriteData), .Rd(Rd),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .stall(stall), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .ALUResult_out(ALUResult_out), .ReadData_out(ReadData_out), .Rd_out(Rd_out),
        .misalign_err(misalign_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Table vectors: single-cycle behaviour, no request may be issued.
    typedef struct {
        logic v, mr, mw, rw, m2r;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  sz;
        logic e_rw, e_m2r, e_mis;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    // Scoreboard entry for a memory access, checked in its DONE cycle.
    typedef struct {
        logic [31:0] rdata;
        logic        rw;
        logic        berr;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];

    task automatic idle_inputs();
        in_valid = 0; MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
        ALUResult = 0; WriteData = 0; Rd = 0; mem_size = 0; mem_unsigned = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Issue one aligned access; ack on BUSY cycle ack_at (0 = never).
    task automatic mem_access(input string nm, input logic rd_op,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] sz, input logic uns,
                              input logic [31:0] rdata, input int ack_at,
                              input logic [3:0] e_be, input logic [31:0] e_wd,
                              input int e_stall, input int e_req, input exp_t e);
        int   stall_n, req_n, busy_n;
        bit   done;
        exp_t got;
        sb.push_back(e);
        in_valid = 1; MemRead = rd_op; MemWrite = ~rd_op;
        RegWrite = rd_op; MemtoReg = rd_op;
        ALUResult = addr; WriteData = wd; Rd = 5'd12;
        mem_size = sz; mem_unsigned = uns; dmem_ack = 0; dmem_rdata = 0;
        #1;
        chk({nm, " issue stall/bubble"}, {30'd0, stall, RegWrite_out}, 32'h2);
        stall_n = stall ? 1 : 0;
        req_n = 0; busy_n = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            dmem_ack = 0;
            if (!stall) begin
                done = 1;
            end else begin
                stall_n++; busy_n++;
                if (dmem_req) req_n++;
                if (busy_n == 1) begin
                    chk({nm, " addr"}, dmem_addr, {addr[31:2], 2'b00});
                    chk({nm, " be"}, {28'd0, dmem_be}, {28'd0, e_be});
                    chk({nm, " we"}, {31'd0, dmem_we}, {31'd0, ~rd_op});
                    if (!rd_op) chk({nm, " wdata"}, dmem_wdata, e_wd);
                end
                if (busy_n == ack_at) begin
                    dmem_ack = 1; dmem_rdata = rdata;
                end
            end
        end
        got = sb.pop_front();
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s done: stall still high after 40 cycles, expected release", nm);
        end else begin
            chk({nm, " stall cycles"}, stall_n, e_stall);
            chk({nm, " req cycles"}, req_n, e_req);
            chk({nm, " RegWrite_out"}, {31'd0, RegWrite_out}, {31'd0, got.rw});
            chk({nm, " bus_err"}, {31'd0, bus_err}, {31'd0, got.berr});
            if (got.chk_rd) chk({nm, " ReadData_out"}, ReadData_out, got.rdata);
            chk({nm, " Rd_out"}, {27'd0, Rd_out}, 32'd12);
            chk({nm, " req low in DONE"}, {31'd0, dmem_req}, 32'd0);
        end
        idle_inputs();
        @(posedge clk); #1;
        chk({nm, " post bus_err"}, {31'd0, bus_err}, 32'd0);
        chk({nm, " post stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        // v mr mw rw m2r alu rd sz | e_rw e_m2r e_mis e_alu e_rd
        vecs[0] = '{1,0,0,1,0, 32'h0000_1234,  5, 2'd2, 1,0,0, 32'h0000_1234,  5};
        vecs[1] = '{0,0,0,1,0, 32'h0000_CAFE,  3, 2'd2, 0,0,0, 32'h0000_CAFE,  3};
        vecs[2] = '{1,1,0,1,1, 32'h0000_0101,  8, 2'd2, 0,1,1, 32'h0000_0101,  8};
        vecs[3] = '{1,1,0,1,1, 32'h0000_0103,  9, 2'd1, 0,1,1, 32'h0000_0103,  9};
        vecs[4] = '{1,0,1,0,0, 32'h0000_0202,  2, 2'd3, 0,0,1, 32'h0000_0202,  2};
        vecs[5] = '{0,1,0,1,1, 32'h0000_0101,  4, 2'd2, 0,1,0, 32'h0000_0101,  4};
        vecs[6] = '{1,0,0,0,0, 32'hFFFF_FFFF, 31, 2'd2, 0,0,0, 32'hFFFF_FFFF, 31};

        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset dmem_addr", dmem_addr, 32'd0);
        chk("reset dmem_wdata", dmem_wdata, 32'd0);
        chk("reset dmem_be/we", {27'd0, dmem_we, dmem_be}, 32'd0);
        chk("reset stall/errs", {29'd0, stall, bus_err, misalign_err}, 32'd0);
        chk("reset ReadData_out", ReadData_out, 32'd0);
        reset = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].v; MemRead = vecs[i].mr; MemWrite = vecs[i].mw;
            RegWrite = vecs[i].rw; MemtoReg = vecs[i].m2r;
            ALUResult = vecs[i].alu; Rd = vecs[i].rd; mem_size = vecs[i].sz;
            WriteData = 32'h5555_AAAA; mem_unsigned = 0;
            dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;   // stray ack must be ignored
            #1;
            chk($sformatf("vec%0d stall", i), {31'd0, stall}, 32'd0);
            chk($sformatf("vec%0d RegWrite_out", i), {31'd0, RegWrite_out}, {31'd0, vecs[i].e_rw});
            chk($sformatf("vec%0d MemtoReg_out", i), {31'd0, MemtoReg_out}, {31'd0, vecs[i].e_m2r});
            chk($sformatf("vec%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
            chk($sformatf("vec%0d ALUResult_out", i), ALUResult_out, vecs[i].e_alu);
            chk($sformatf("vec%0d Rd_out", i), {27'd0, Rd_out}, {27'd0, vecs[i].e_rd});
            chk($sformatf("vec%0d ReadData_out", i), ReadData_out, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d no dmem_req", i), {31'd0, dmem_req}, 32'd0);
        end
        idle_inputs();
        @(posedge clk); #1;

        //          name   rd addr          wdata         sz uns rdata        ack be       e_wdata       stall req  {rdata, rw, berr, chk_rd}
        mem_access("lb",  1, 32'h0000_0103, 32'd0,        0, 0, 32'h80AA_BBCC, 1, 4'b1000, 32'd0,         2, 1, '{32'hFFFF_FF80, 1, 0, 1});
        mem_access("lbu", 1, 32'h0000_0103, 32'd0,        0, 1, 32'h80AA_BBCC, 1, 4'b1000, 32'd0,         2, 1, '{32'h0000_0080, 1, 0, 1});
        mem_access("lh",  1, 32'h0000_0102, 32'd0,        1, 0, 32'h80AA_BBCC, 1, 4'b1100, 32'd0,         2, 1, '{32'hFFFF_80AA, 1, 0, 1});
        mem_access("lhu", 1, 32'h0000_0102, 32'd0,        1, 1, 32'h80AA_BBCC, 2, 4'b1100, 32'd0,         3, 2, '{32'h0000_80AA, 1, 0, 1});
        mem_access("lw",  1, 32'h0000_0200, 32'd0,        2, 1, 32'h80AA_BBCC, 2, 4'b1111, 32'd0,         3, 2, '{32'h80AA_BBCC, 1, 0, 1});
        mem_access("sh",  0, 32'h0000_0102, 32'hDEADBEEF, 1, 0, 32'd0,         4, 4'b1100, 32'hBEEF_BEEF, 5, 4, '{32'd0, 0, 0, 1});
        mem_access("sb",  0, 32'h0000_0101, 32'hDEADBEEF, 0, 0, 32'd0,         1, 4'b0010, 32'hEFEF_EFEF, 2, 1, '{32'd0, 0, 0, 1});
        mem_access("sw",  0, 32'h0000_0204, 32'h12345678, 2, 0, 32'd0,         3, 4'b1111, 32'h1234_5678, 4, 3, '{32'd0, 0, 0, 1});
        mem_access("tmo", 1, 32'h0000_0200, 32'd0,        2, 0, 32'd0,         0, 4'b1111, 32'd0,         5, 4, '{32'd0, 0, 1, 0});

        // Reset while BUSY, with an ack arriving afterwards.
        in_valid = 1; MemRead = 1; RegWrite = 1; MemtoReg = 1;
        ALUResult = 32'h0000_0300; Rd = 5'd6; mem_size = 2;
        @(posedge clk); #1;
        chk("rst busy req", {31'd0, dmem_req}, 32'd1);
        reset = 1;
        idle_inputs();
        #1;
        chk("rst dmem_req drop", {31'd0, dmem_req}, 32'd0);
        chk("rst dmem_addr/be", {dmem_addr[27:0], dmem_be}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        dmem_ack = 1; dmem_rdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        reset = 0;
        in_valid = 1; RegWrite = 1; ALUResult = 32'h55; Rd = 5'd9;
        #1;
        chk("post-rst stall", {31'd0, stall}, 32'd0);
        chk("post-rst RegWrite_out", {31'd0, RegWrite_out}, 32'd1);
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("post-rst no DONE data", ReadData_out, 32'd0);
        chk("post-rst req/bus_err/stall", {29'd0, dmem_req, bus_err, stall}, 32'd0);
        chk("post-rst Rd_out", {27'd0, Rd_out}, 32'd9);
        idle_inputs();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
